// File: rtl/key_timer_pkg.sv
// Shared types and defaults for the key hold timer: FSM state encoding,
// default debounce/tick constants and a counter-width helper.
package key_timer_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DOWN_FILT = 2'd1,
      PRESSED   = 2'd2,
      UP_FILT   = 2'd3
   } key_fsm_e;

   localparam int DEB_CYCLES_DEF = 1_000_000;
   localparam int TICK_DIV_DEF   = 50_000;

   // Bits needed to count 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider for hold timing: pulses tick on every TICK_DIV-th
// enabled cycle; clr restarts the count so a new press starts on a clean phase.
module tick_prescaler
   import key_timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = cnt_w(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (clr) begin
         pre_cnt <= '0;
      end else if (en) begin
         if (pre_cnt == PRE_LAST) pre_cnt <= '0;
         else                     pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Tick is combinational so the hold counter can fold in the wrap cycle.
   assign tick = en && (pre_cnt == PRE_LAST);

endmodule

// File: rtl/key_hold_timer.sv
// Debounces an active-low key, flags accepted edges and reports how many
// prescaled ticks the key was held for the most recent completed press.
module key_hold_timer
   import key_timer_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int COUNT_W    = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_in,
   output logic               key_flag,
   output logic               key_state,
   output logic [COUNT_W-1:0] count_out,
   output logic               count_valid
);

   localparam int DW = cnt_w(DEB_CYCLES);
   localparam logic [DW-1:0]      DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [COUNT_W-1:0] HOLD_MAX = '1;

   logic sync_1;
   logic ks;

   key_fsm_e state;
   key_fsm_e state_nxt;

   logic [DW-1:0]      deb_cnt;
   logic [DW-1:0]      deb_cnt_nxt;
   logic [COUNT_W-1:0] hold_cnt;
   logic [COUNT_W-1:0] hold_cnt_nxt;
   logic [COUNT_W-1:0] hold_inc;
   logic               key_state_nxt;
   logic               key_flag_nxt;
   logic [COUNT_W-1:0] count_out_nxt;
   logic               count_valid_nxt;

   logic timing;
   logic pre_clr;
   logic tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         ks     <= 1'b1;
      end else begin
         sync_1 <= key_in;
         ks     <= sync_1;
      end
   end

   assign timing  = (state == PRESSED) || (state == UP_FILT);
   assign pre_clr = (state == DOWN_FILT) && !ks && (deb_cnt == DEB_LAST);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .en    (timing),
      .tick  (tick)
   );

   // Saturating next hold value, including a tick that lands this cycle.
   assign hold_inc = (tick && (hold_cnt != HOLD_MAX)) ? hold_cnt + 1'b1 : hold_cnt;

   always_comb begin
      state_nxt       = state;
      deb_cnt_nxt     = deb_cnt;
      hold_cnt_nxt    = timing ? hold_inc : hold_cnt;
      key_state_nxt   = key_state;
      key_flag_nxt    = 1'b0;
      count_out_nxt   = count_out;
      count_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (!ks) begin
               state_nxt   = DOWN_FILT;
               deb_cnt_nxt = '0;
            end
         end
         DOWN_FILT: begin
            if (ks) begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt     = PRESSED;
               deb_cnt_nxt   = '0;
               key_state_nxt = 1'b0;
               key_flag_nxt  = 1'b1;
               hold_cnt_nxt  = '0;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (ks) begin
               state_nxt   = UP_FILT;
               deb_cnt_nxt = '0;
            end
         end
         UP_FILT: begin
            // A bounce back low resumes the press without touching the timing.
            if (!ks) begin
               state_nxt   = PRESSED;
               deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt       = IDLE;
               deb_cnt_nxt     = '0;
               key_state_nxt   = 1'b1;
               key_flag_nxt    = 1'b1;
               count_out_nxt   = hold_inc;
               count_valid_nxt = 1'b1;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            deb_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         key_state   <= 1'b1;
         key_flag    <= 1'b0;
         count_out   <= '0;
         count_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         deb_cnt     <= deb_cnt_nxt;
         hold_cnt    <= hold_cnt_nxt;
         key_state   <= key_state_nxt;
         key_flag    <= key_flag_nxt;
         count_out   <= count_out_nxt;
         count_valid <= count_valid_nxt;
      end
   end

endmodule
